// File: rtl/core_defs.sv
// Shared core definitions: opcodes, operand-mux encodings and the
// in-flight write slot used by the forwarding/hazard logic.
package core_defs;

    localparam int REG_ADDR = 5;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [1:0] SEL1_RS  = 2'b00;
    localparam logic [1:0] SEL1_FWD = 2'b01;
    localparam logic [1:0] SEL1_PC  = 2'b10;

    localparam logic [1:0] SEL2_RS   = 2'b00;
    localparam logic [1:0] SEL2_FWD  = 2'b01;
    localparam logic [1:0] SEL2_IMM  = 2'b10;
    localparam logic [1:0] SEL2_FOUR = 2'b11;

    typedef struct packed {
        logic                valid;
        logic [REG_ADDR-1:0] rd;
        logic                wr_en;
        logic                is_load;
    } slot_t;

    // A slot can supply rs when it will write that register; x0 never matches.
    function automatic logic slot_match(slot_t s, logic [REG_ADDR-1:0] rs);
        return s.valid & s.wr_en & (s.rd == rs) & (rs != '0);
    endfunction

endpackage

// File: rtl/forwarding_hazard_unit_if.sv
// ID-side request, pipeline results and the registered ALU operand
// controls exchanged between the decoder/ALU and the hazard unit.
interface forwarding_hazard_unit_if
    import core_defs::*;
#(
    parameter int XLEN = 32
) ();

    logic                id_valid;
    logic [6:0]          id_opcode;
    logic [REG_ADDR-1:0] id_rs1;
    logic [REG_ADDR-1:0] id_rs2;
    logic [REG_ADDR-1:0] id_rd;
    logic                flush;
    logic [XLEN-1:0]     ex_result;
    logic [XLEN-1:0]     mem_result;
    logic [XLEN-1:0]     wb_result;
    logic [1:0]          mux1_select;
    logic [1:0]          mux2_select;
    logic [XLEN-1:0]     forward_rs1;
    logic [XLEN-1:0]     forward_rs2;
    logic                stall;

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd, flush,
        output ex_result, mem_result, wb_result,
        input  mux1_select, mux2_select, forward_rs1, forward_rs2, stall
    );

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, flush,
        input  ex_result, mem_result, wb_result,
        output mux1_select, mux2_select, forward_rs1, forward_rs2, stall
    );

endinterface

// File: rtl/operand_forward_select.sv
// Picks the youngest in-flight producer of one source register and
// returns its result; the youngest producer holds the architectural value.
module operand_forward_select
    import core_defs::*;
#(
    parameter int XLEN = 32
) (
    input  logic [REG_ADDR-1:0] i_rs,
    input  logic                i_use,
    input  slot_t               i_ex_slot,
    input  slot_t               i_mem_slot,
    input  slot_t               i_wb_slot,
    input  logic [XLEN-1:0]     i_ex_result,
    input  logic [XLEN-1:0]     i_mem_result,
    input  logic [XLEN-1:0]     i_wb_result,
    output logic                o_hit,
    output logic [XLEN-1:0]     o_fwd_value
);

    // Priority ex > mem > wb so the most recent write wins.
    always_comb begin
        o_hit       = 1'b0;
        o_fwd_value = '0;
        if (i_use) begin
            if (slot_match(i_ex_slot, i_rs)) begin
                o_hit       = 1'b1;
                o_fwd_value = i_ex_result;
            end else if (slot_match(i_mem_slot, i_rs)) begin
                o_hit       = 1'b1;
                o_fwd_value = i_mem_result;
            end else if (slot_match(i_wb_slot, i_rs)) begin
                o_hit       = 1'b1;
                o_fwd_value = i_wb_result;
            end
        end
    end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Tracks in-flight writes, registers ALU operand selects/bypass values
// into EX, and stalls ID one cycle on a load-use dependency.
module forwarding_hazard_unit
    import core_defs::*;
#(
    parameter int XLEN = 32
) (
    input logic                     clk,
    input logic                     reset,
    forwarding_hazard_unit_if.slave bus
);

    slot_t           r_ex;
    slot_t           r_mem;
    slot_t           r_wb;
    logic [1:0]      r_sel1;
    logic [1:0]      r_sel2;
    logic [XLEN-1:0] r_fwd1;
    logic [XLEN-1:0] r_fwd2;

    logic            w_use1_fwd;
    logic            w_use1_chk;
    logic            w_use2;
    logic [1:0]      w_sel1;
    logic [1:0]      w_sel2;
    logic            w_wr_en;
    logic            w_is_load;
    slot_t           w_id_slot;
    logic            w_hit1;
    logic            w_hit2;
    logic [XLEN-1:0] w_fwd1;
    logic [XLEN-1:0] w_fwd2;
    logic            w_ld1;
    logic            w_ld2;
    logic            w_stall;
    logic            w_issue;

    // Decode operand usage and base selects; JALR checks rs1 but drives PC.
    always_comb begin
        w_use1_fwd = 1'b0;
        w_use1_chk = 1'b0;
        w_use2     = 1'b0;
        w_sel1     = SEL1_RS;
        w_sel2     = SEL2_RS;
        w_wr_en    = 1'b0;
        w_is_load  = 1'b0;
        unique case (1'b1)
            (bus.id_opcode == OP_R): begin
                w_use1_fwd = 1'b1;
                w_use1_chk = 1'b1;
                w_use2     = 1'b1;
                w_wr_en    = 1'b1;
            end
            (bus.id_opcode == OP_I): begin
                w_use1_fwd = 1'b1;
                w_use1_chk = 1'b1;
                w_sel2     = SEL2_IMM;
                w_wr_en    = 1'b1;
            end
            (bus.id_opcode == OP_LOAD): begin
                w_use1_fwd = 1'b1;
                w_use1_chk = 1'b1;
                w_sel2     = SEL2_IMM;
                w_wr_en    = 1'b1;
                w_is_load  = 1'b1;
            end
            (bus.id_opcode == OP_STORE): begin
                w_use1_fwd = 1'b1;
                w_use1_chk = 1'b1;
                w_sel2     = SEL2_IMM;
            end
            (bus.id_opcode == OP_JAL): begin
                w_sel1  = SEL1_PC;
                w_sel2  = SEL2_FOUR;
                w_wr_en = 1'b1;
            end
            (bus.id_opcode == OP_JALR): begin
                w_use1_chk = 1'b1;
                w_sel1     = SEL1_PC;
                w_sel2     = SEL2_FOUR;
                w_wr_en    = 1'b1;
            end
            (bus.id_opcode == OP_AUIPC): begin
                w_sel1  = SEL1_PC;
                w_sel2  = SEL2_IMM;
                w_wr_en = 1'b1;
            end
            (bus.id_opcode == OP_LUI): begin
                w_wr_en = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Slot image of the ID instruction if it issues this cycle.
    always_comb begin
        w_id_slot         = '0;
        w_id_slot.valid   = 1'b1;
        w_id_slot.rd      = bus.id_rd;
        w_id_slot.wr_en   = w_wr_en;
        w_id_slot.is_load = w_is_load;
    end

    operand_forward_select #(.XLEN(XLEN)) u_op1 (
        .i_rs         (bus.id_rs1),
        .i_use        (w_use1_fwd),
        .i_ex_slot    (r_ex),
        .i_mem_slot   (r_mem),
        .i_wb_slot    (r_wb),
        .i_ex_result  (bus.ex_result),
        .i_mem_result (bus.mem_result),
        .i_wb_result  (bus.wb_result),
        .o_hit        (w_hit1),
        .o_fwd_value  (w_fwd1)
    );

    operand_forward_select #(.XLEN(XLEN)) u_op2 (
        .i_rs         (bus.id_rs2),
        .i_use        (w_use2),
        .i_ex_slot    (r_ex),
        .i_mem_slot   (r_mem),
        .i_wb_slot    (r_wb),
        .i_ex_result  (bus.ex_result),
        .i_mem_result (bus.mem_result),
        .i_wb_result  (bus.wb_result),
        .o_hit        (w_hit2),
        .o_fwd_value  (w_fwd2)
    );

    // Load data is not ready until MEM, so a dependent in ID must wait.
    assign w_ld1   = w_use1_chk & r_ex.is_load & slot_match(r_ex, bus.id_rs1);
    assign w_ld2   = w_use2 & r_ex.is_load & slot_match(r_ex, bus.id_rs2);
    assign w_stall = bus.id_valid & ~bus.flush & (w_ld1 | w_ld2);
    assign w_issue = bus.id_valid & ~bus.flush & ~w_stall;

    // Advance the write slots and register EX operand controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex   <= '0;
            r_mem  <= '0;
            r_wb   <= '0;
            r_sel1 <= SEL1_RS;
            r_sel2 <= SEL2_RS;
            r_fwd1 <= '0;
            r_fwd2 <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            if (w_issue) begin
                r_ex   <= w_id_slot;
                r_sel1 <= w_hit1 ? SEL1_FWD : w_sel1;
                r_sel2 <= w_hit2 ? SEL2_FWD : w_sel2;
                if (w_hit1) begin
                    r_fwd1 <= w_fwd1;
                end
                if (w_hit2) begin
                    r_fwd2 <= w_fwd2;
                end
            end else begin
                r_ex   <= '0;
                r_sel1 <= SEL1_RS;
                r_sel2 <= SEL2_RS;
            end
        end
    end

    assign bus.mux1_select = r_sel1;
    assign bus.mux2_select = r_sel2;
    assign bus.forward_rs1 = r_fwd1;
    assign bus.forward_rs2 = r_fwd2;
    assign bus.stall       = w_stall;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed-vector bench for forwarding_hazard_unit: forwarding paths,
// load-use stall, flush, x0 and reset behaviour.
module tb_forwarding_hazard_unit;

    localparam logic [6:0] R_OP  = 7'b0110011;
    localparam logic [6:0] I_OP  = 7'b0010011;
    localparam logic [6:0] LD_OP = 7'b0000011;
    localparam logic [6:0] JL_OP = 7'b1101111;
    localparam logic [6:0] JR_OP = 7'b1100111;
    localparam logic [6:0] AU_OP = 7'b0010111;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    forwarding_hazard_unit_if #(.XLEN(32)) bus ();

    forwarding_hazard_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [6:0] op,
                         input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d);
        bus.id_valid  = v;
        bus.id_opcode = op;
        bus.id_rs1    = s1;
        bus.id_rs2    = s2;
        bus.id_rd     = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        repeat (3) tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        n_cmp++; if (bus.mux1_select !== 2'b00) begin n_bad++; $display("FAIL reset sel1 got %b want 00", bus.mux1_select); end
        n_cmp++; if (bus.mux2_select !== 2'b00) begin n_bad++; $display("FAIL reset sel2 got %b want 00", bus.mux2_select); end
        n_cmp++; if (bus.forward_rs1 !== 32'h0) begin n_bad++; $display("FAIL reset fwd1 got %h want 0", bus.forward_rs1); end
        n_cmp++; if (bus.forward_rs2 !== 32'h0) begin n_bad++; $display("FAIL reset fwd2 got %h want 0", bus.forward_rs2); end
        n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL reset stall got %b want 0", bus.stall); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_ex_forward;
        drive(1'b1, R_OP, 5'd1, 5'd2, 5'd5);
        tick();
        drive(1'b1, R_OP, 5'd5, 5'd1, 5'd6);
        bus.ex_result = 32'h11;
        #1;
        n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL ex_fwd stall got %b want 0", bus.stall); end
        tick();
        n_cmp++; if (bus.mux1_select !== 2'b01) begin n_bad++; $display("FAIL ex_fwd sel1 got %b want 01", bus.mux1_select); end
        n_cmp++; if (bus.forward_rs1 !== 32'h11) begin n_bad++; $display("FAIL ex_fwd fwd1 got %h want 11", bus.forward_rs1); end
        n_cmp++; if (bus.mux2_select !== 2'b00) begin n_bad++; $display("FAIL ex_fwd sel2 got %b want 00", bus.mux2_select); end
        drain();
    endtask

    task automatic test_mem_forward;
        drive(1'b1, I_OP, 5'd0, 5'd0, 5'd7);
        tick();
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b1, R_OP, 5'd2, 5'd7, 5'd8);
        bus.ex_result  = 32'h99;
        bus.mem_result = 32'h22;
        #1;
        n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL mem_fwd stall got %b want 0", bus.stall); end
        tick();
        n_cmp++; if (bus.mux2_select !== 2'b01) begin n_bad++; $display("FAIL mem_fwd sel2 got %b want 01", bus.mux2_select); end
        n_cmp++; if (bus.forward_rs2 !== 32'h22) begin n_bad++; $display("FAIL mem_fwd fwd2 got %h want 22", bus.forward_rs2); end
        n_cmp++; if (bus.mux1_select !== 2'b00) begin n_bad++; $display("FAIL mem_fwd sel1 got %b want 00", bus.mux1_select); end
        drain();
    endtask

    task automatic test_priority;
        repeat (3) begin
            drive(1'b1, I_OP, 5'd0, 5'd0, 5'd20);
            tick();
        end
        drive(1'b1, R_OP, 5'd20, 5'd0, 5'd21);
        bus.ex_result  = 32'h3;
        bus.mem_result = 32'h2;
        bus.wb_result  = 32'h1;
        tick();
        n_cmp++; if (bus.forward_rs1 !== 32'h3) begin n_bad++; $display("FAIL prio fwd1 got %h want 3", bus.forward_rs1); end
        n_cmp++; if (bus.mux2_select !== 2'b00) begin n_bad++; $display("FAIL prio x0 sel2 got %b want 00", bus.mux2_select); end
        drain();
        drive(1'b1, I_OP, 5'd0, 5'd0, 5'd22);
        tick();
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        drive(1'b1, R_OP, 5'd0, 5'd22, 5'd23);
        bus.ex_result  = 32'h77;
        bus.mem_result = 32'h66;
        bus.wb_result  = 32'h44;
        tick();
        n_cmp++; if (bus.mux2_select !== 2'b01) begin n_bad++; $display("FAIL wb_fwd sel2 got %b want 01", bus.mux2_select); end
        n_cmp++; if (bus.forward_rs2 !== 32'h44) begin n_bad++; $display("FAIL wb_fwd fwd2 got %h want 44", bus.forward_rs2); end
        drain();
    endtask

    task automatic test_load_use;
        drive(1'b1, LD_OP, 5'd3, 5'd0, 5'd9);
        tick();
        drive(1'b1, R_OP, 5'd9, 5'd9, 5'd10);
        bus.ex_result  = 32'h5555;
        bus.mem_result = 32'hDEAD;
        #1;
        n_cmp++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL lu stall got %b want 1", bus.stall); end
        tick();
        n_cmp++; if (bus.mux1_select !== 2'b00) begin n_bad++; $display("FAIL lu bubble sel1 got %b want 00", bus.mux1_select); end
        n_cmp++; if (bus.mux2_select !== 2'b00) begin n_bad++; $display("FAIL lu bubble sel2 got %b want 00", bus.mux2_select); end
        n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL lu stall2 got %b want 0", bus.stall); end
        tick();
        n_cmp++; if (bus.mux1_select !== 2'b01) begin n_bad++; $display("FAIL lu sel1 got %b want 01", bus.mux1_select); end
        n_cmp++; if (bus.mux2_select !== 2'b01) begin n_bad++; $display("FAIL lu sel2 got %b want 01", bus.mux2_select); end
        n_cmp++; if (bus.forward_rs1 !== 32'hDEAD) begin n_bad++; $display("FAIL lu fwd1 got %h want dead", bus.forward_rs1); end
        n_cmp++; if (bus.forward_rs2 !== 32'hDEAD) begin n_bad++; $display("FAIL lu fwd2 got %h want dead", bus.forward_rs2); end
        drain();
    endtask

    task automatic test_x0;
        drive(1'b1, LD_OP, 5'd3, 5'd0, 5'd0);
        tick();
        drive(1'b1, R_OP, 5'd0, 5'd0, 5'd1);
        #1;
        n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL x0 stall got %b want 0", bus.stall); end
        tick();
        n_cmp++; if (bus.mux1_select !== 2'b00) begin n_bad++; $display("FAIL x0 sel1 got %b want 00", bus.mux1_select); end
        n_cmp++; if (bus.mux2_select !== 2'b00) begin n_bad++; $display("FAIL x0 sel2 got %b want 00", bus.mux2_select); end
        drain();
    endtask

    task automatic test_jump_flush;
        drive(1'b1, JL_OP, 5'd0, 5'd0, 5'd1);
        tick();
        n_cmp++; if (bus.mux1_select !== 2'b10) begin n_bad++; $display("FAIL jal sel1 got %b want 10", bus.mux1_select); end
        n_cmp++; if (bus.mux2_select !== 2'b11) begin n_bad++; $display("FAIL jal sel2 got %b want 11", bus.mux2_select); end
        drive(1'b1, LD_OP, 5'd3, 5'd0, 5'd11);
        tick();
        drive(1'b1, R_OP, 5'd11, 5'd0, 5'd12);
        bus.flush = 1'b1;
        #1;
        n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL flush stall got %b want 0", bus.stall); end
        tick();
        bus.flush = 1'b0;
        n_cmp++; if (bus.mux1_select !== 2'b00) begin n_bad++; $display("FAIL flush sel1 got %b want 00", bus.mux1_select); end
        drive(1'b1, R_OP, 5'd11, 5'd0, 5'd13);
        bus.mem_result = 32'hBEEF;
        #1;
        n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL postflush stall got %b want 0", bus.stall); end
        tick();
        n_cmp++; if (bus.forward_rs1 !== 32'hBEEF) begin n_bad++; $display("FAIL postflush fwd1 got %h want beef", bus.forward_rs1); end
        drain();
        drive(1'b1, AU_OP, 5'd0, 5'd0, 5'd2);
        tick();
        n_cmp++; if (bus.mux1_select !== 2'b10) begin n_bad++; $display("FAIL auipc sel1 got %b want 10", bus.mux1_select); end
        n_cmp++; if (bus.mux2_select !== 2'b10) begin n_bad++; $display("FAIL auipc sel2 got %b want 10", bus.mux2_select); end
        drain();
        drive(1'b1, LD_OP, 5'd3, 5'd0, 5'd14);
        tick();
        drive(1'b1, JR_OP, 5'd14, 5'd0, 5'd1);
        #1;
        n_cmp++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL jalr stall got %b want 1", bus.stall); end
        tick();
        tick();
        n_cmp++; if (bus.mux1_select !== 2'b10) begin n_bad++; $display("FAIL jalr sel1 got %b want 10", bus.mux1_select); end
        n_cmp++; if (bus.mux2_select !== 2'b11) begin n_bad++; $display("FAIL jalr sel2 got %b want 11", bus.mux2_select); end
        drain();
    endtask

    task automatic test_reset_mid_stall;
        drive(1'b1, LD_OP, 5'd3, 5'd0, 5'd15);
        tick();
        drive(1'b1, R_OP, 5'd15, 5'd0, 5'd16);
        #1;
        n_cmp++; if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL rst_stall pre got %b want 1", bus.stall); end
        reset = 1'b1;
        tick();
        n_cmp++; if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall stall got %b want 0", bus.stall); end
        n_cmp++; if (bus.mux1_select !== 2'b00) begin n_bad++; $display("FAIL rst_stall sel1 got %b want 00", bus.mux1_select); end
        n_cmp++; if (bus.mux2_select !== 2'b00) begin n_bad++; $display("FAIL rst_stall sel2 got %b want 00", bus.mux2_select); end
        n_cmp++; if (bus.forward_rs1 !== 32'h0) begin n_bad++; $display("FAIL rst_stall fwd1 got %h want 0", bus.forward_rs1); end
        n_cmp++; if (bus.forward_rs2 !== 32'h0) begin n_bad++; $display("FAIL rst_stall fwd2 got %h want 0", bus.forward_rs2); end
        reset = 1'b0;
        drain();
    endtask

    // Run all scenarios in order and report.
    initial begin
        clk            = 1'b0;
        reset          = 1'b1;
        n_cmp          = 0;
        n_bad          = 0;
        bus.flush      = 1'b0;
        bus.ex_result  = '0;
        bus.mem_result = '0;
        bus.wb_result  = '0;
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        test_reset();
        test_ex_forward();
        test_mem_forward();
        test_priority();
        test_load_use();
        test_x0();
        test_jump_flush();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
